// File: rtl/matmul_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_engine                                                   |
// | Purpose  : Streams C_m = A x B_m for NUM_MATS weight matrices through one  |
// |            MAC. It uses 1-cycle SRAM reads and one (A,B) fetch per cycle.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module matmul_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int NUM_MATS = 3,
    parameter int SAT_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic              err,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic [ADDR_W-1:0] wt_rd_addr,
    input  logic [DATA_W-1:0] wt_rd_data,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0] res_wr_data
);

    localparam int                ACC_W    = 2 * DATA_W + 16;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_MAT = ADDR_W'(NUM_MATS - 1);
    localparam logic [ACC_W-1:0]  SAT_MAX  = ACC_W'({DATA_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE, HDR_REQ, HDR_WAIT, CHECK, RUN, DRAIN, DONE
    } state_t;

    state_t              state_q, state_d;
    logic                err_q, err_d;
    logic                drain_q, drain_d;
    logic [ADDR_W-1:0]   r_dim_q, r_dim_d, k_dim_q, k_dim_d;
    logic [ADDR_W-1:0]   kw_dim_q, kw_dim_d, n_dim_q, n_dim_d;
    logic [ADDR_W-1:0]   k_idx_q, k_idx_d, n_idx_q, n_idx_d;
    logic [ADDR_W-1:0]   r_idx_q, r_idx_d, m_idx_q, m_idx_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, m_base_q, m_base_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic                p1_vld_q, p1_vld_d, p1_first_q, p1_first_d, p1_last_q, p1_last_d;
    logic [ADDR_W-1:0]   p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;
    logic                p2_we_q, p2_we_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic [2*DATA_W-1:0] w_prod;
    logic                w_k_last, w_n_last, w_r_last, w_m_last, w_hdr_bad, w_issue;
    logic [DATA_W-1:0]   w_res;

    assign w_prod    = (2*DATA_W)'(in_rd_data) * (2*DATA_W)'(wt_rd_data);
    assign w_k_last  = (k_idx_q == k_dim_q - ADDR_ONE);
    assign w_n_last  = (n_idx_q == n_dim_q - ADDR_ONE);
    assign w_r_last  = (r_idx_q == r_dim_q - ADDR_ONE);
    assign w_m_last  = (m_idx_q == LAST_MAT);
    assign w_hdr_bad = (r_dim_q == '0) || (k_dim_q == '0) || (n_dim_q == '0) || (k_dim_q != kw_dim_q);
    assign w_issue   = (state_q == RUN) && !reset;

    generate
        if (SAT_EN != 0) begin : g_sat
            assign w_res = (acc_q > SAT_MAX) ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
        end else begin : g_wrap
            assign w_res = acc_q[DATA_W-1:0];
        end
    endgenerate

    assign dut_ready   = reset || (state_q == IDLE);
    assign err         = err_q && !reset;
    assign res_we      = p2_we_q && !reset;
    assign res_wr_addr = res_we ? p2_addr_q : '0;
    assign res_wr_data = res_we ? w_res : '0;
    assign in_rd_addr  = w_issue ? a_base_q + k_idx_q : '0;
    assign wt_rd_addr  = w_issue ? b_base_q + k_idx_q : '0;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        drain_d   = drain_q;
        r_dim_d   = r_dim_q;
        k_dim_d   = k_dim_q;
        kw_dim_d  = kw_dim_q;
        n_dim_d   = n_dim_q;
        k_idx_d   = k_idx_q;
        n_idx_d   = n_idx_q;
        r_idx_d   = r_idx_q;
        m_idx_d   = m_idx_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        m_base_d  = m_base_q;
        out_idx_d = out_idx_q;
        p1_vld_d   = 1'b0;
        p1_first_d = 1'b0;
        p1_last_d  = 1'b0;
        p1_addr_d  = p1_addr_q;
        // Stage 2 sees the sum one cycle after its final operand pair arrived.
        p2_we_d    = p1_vld_q && p1_last_q;
        p2_addr_d  = p1_addr_q;
        acc_d      = acc_q;
        if (p1_vld_q) begin
            acc_d = p1_first_q ? ACC_W'(w_prod) : acc_q + ACC_W'(w_prod);
        end

        case (state_q)
            IDLE: begin
                if (dut_valid) state_d = HDR_REQ;
            end
            HDR_REQ: state_d = HDR_WAIT;
            HDR_WAIT: begin
                r_dim_d  = ADDR_W'(in_rd_data[31:16]);
                k_dim_d  = ADDR_W'(in_rd_data[15:0]);
                kw_dim_d = ADDR_W'(wt_rd_data[31:16]);
                n_dim_d  = ADDR_W'(wt_rd_data[15:0]);
                state_d  = CHECK;
            end
            CHECK: begin
                k_idx_d   = '0;
                n_idx_d   = '0;
                r_idx_d   = '0;
                m_idx_d   = '0;
                a_base_d  = ADDR_ONE;
                b_base_d  = ADDR_ONE;
                m_base_d  = ADDR_ONE;
                out_idx_d = '0;
                err_d     = w_hdr_bad;
                state_d   = w_hdr_bad ? DONE : RUN;
            end
            RUN: begin
                p1_vld_d   = 1'b1;
                p1_first_d = (k_idx_q == '0);
                p1_last_d  = w_k_last;
                p1_addr_d  = out_idx_q;
                if (!w_k_last) begin
                    k_idx_d = k_idx_q + ADDR_ONE;
                end else begin
                    k_idx_d   = '0;
                    out_idx_d = out_idx_q + ADDR_ONE;
                    if (!w_n_last) begin
                        n_idx_d  = n_idx_q + ADDR_ONE;
                        b_base_d = b_base_q + k_dim_q;
                    end else begin
                        n_idx_d = '0;
                        if (!w_r_last) begin
                            r_idx_d  = r_idx_q + ADDR_ONE;
                            a_base_d = a_base_q + k_dim_q;
                            b_base_d = m_base_q;
                        end else begin
                            // Column after the last one of B_m is the first of B_(m+1).
                            r_idx_d  = '0;
                            a_base_d = ADDR_ONE;
                            b_base_d = b_base_q + k_dim_q;
                            m_base_d = b_base_q + k_dim_q;
                            if (w_m_last) begin
                                drain_d = 1'b0;
                                state_d = DRAIN;
                            end else begin
                                m_idx_d = m_idx_q + ADDR_ONE;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            drain_q    <= 1'b0;
            r_dim_q    <= '0;
            k_dim_q    <= '0;
            kw_dim_q   <= '0;
            n_dim_q    <= '0;
            k_idx_q    <= '0;
            n_idx_q    <= '0;
            r_idx_q    <= '0;
            m_idx_q    <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            m_base_q   <= '0;
            out_idx_q  <= '0;
            p1_vld_q   <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_addr_q  <= '0;
            p2_we_q    <= 1'b0;
            p2_addr_q  <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
            r_dim_q    <= r_dim_d;
            k_dim_q    <= k_dim_d;
            kw_dim_q   <= kw_dim_d;
            n_dim_q    <= n_dim_d;
            k_idx_q    <= k_idx_d;
            n_idx_q    <= n_idx_d;
            r_idx_q    <= r_idx_d;
            m_idx_q    <= m_idx_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            m_base_q   <= m_base_d;
            out_idx_q  <= out_idx_d;
            p1_vld_q   <= p1_vld_d;
            p1_first_q <= p1_first_d;
            p1_last_q  <= p1_last_d;
            p1_addr_q  <= p1_addr_d;
            p2_we_q    <= p2_we_d;
            p2_addr_q  <= p2_addr_d;
            acc_q      <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matmul_engine                                                |
// | Purpose  : Self-checking bench comparing saturating and wrapping engines   |
// |            against a plain-arithmetic matrix product model.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_matmul_engine;

    localparam int NM = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dut_valid = 1'b0;
    logic        s_ready, s_err, s_we, w_ready, w_err, w_we;
    logic [15:0] s_in_addr, s_wt_addr, s_waddr, w_in_addr, w_wt_addr, w_waddr;
    logic [31:0] s_in_data = '0, s_wt_data = '0, w_in_data = '0, w_wt_data = '0;
    logic [31:0] s_wdata, w_wdata;
    logic [15:0] s_in_al = '0, s_wt_al = '0, w_in_al = '0, w_wt_al = '0;

    logic [31:0] in_mem [0:1023];
    logic [31:0] wt_mem [0:1023];

    logic [15:0] q_addr[$];
    logic [31:0] q_sat[$];
    logic [31:0] q_wrap[$];
    int          q_cyc[$];
    logic [15:0] e_addr[$];
    logic [31:0] e_sat[$];
    logic [31:0] e_wrap[$];
    int          exp_lat;
    bit          exp_err;
    int          cyc = 0;
    int          idle_bad = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    matmul_engine #(.DATA_W(32), .ADDR_W(16), .NUM_MATS(NM), .SAT_EN(1)) u_dut (
        .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(s_ready), .err(s_err),
        .in_rd_addr(s_in_addr), .in_rd_data(s_in_data), .wt_rd_addr(s_wt_addr), .wt_rd_data(s_wt_data),
        .res_we(s_we), .res_wr_addr(s_waddr), .res_wr_data(s_wdata));

    matmul_engine #(.DATA_W(32), .ADDR_W(16), .NUM_MATS(NM), .SAT_EN(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(w_ready), .err(w_err),
        .in_rd_addr(w_in_addr), .in_rd_data(w_in_data), .wt_rd_addr(w_wt_addr), .wt_rd_data(w_wt_data),
        .res_we(w_we), .res_wr_addr(w_waddr), .res_wr_data(w_wdata));

    // SRAM models: address captured mid-cycle, data returned the following cycle.
    always @(negedge clk) begin
        s_in_al = s_in_addr;
        s_wt_al = s_wt_addr;
        w_in_al = w_in_addr;
        w_wt_al = w_wt_addr;
        if (s_we === 1'b1) begin
            q_addr.push_back(s_waddr);
            q_sat.push_back(s_wdata);
            q_cyc.push_back(cyc);
        end else if (s_wdata !== 32'd0) begin
            idle_bad++;
        end
        if (w_we === 1'b1) q_wrap.push_back(w_wdata);
    end

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        s_in_data <= in_mem[s_in_al[9:0]];
        s_wt_data <= wt_mem[s_wt_al[9:0]];
        w_in_data <= in_mem[w_in_al[9:0]];
        w_wt_data <= wt_mem[w_wt_al[9:0]];
    end

    function automatic logic [31:0] elem(input int i, input int mode);
        if (mode == 0) return 32'(i);
        if (mode == 1) return $urandom;
        return 32'($urandom_range(0, 1000));
    endfunction

    task automatic fill(input int r, input int k, input int kw, input int n, input int mode);
        in_mem[0] = {16'(r), 16'(k)};
        wt_mem[0] = {16'(kw), 16'(n)};
        for (int i = 1; i <= r * k; i++) in_mem[i] = elem(i, mode);
        for (int i = 1; i <= NM * kw * n; i++) wt_mem[i] = elem(i, mode);
    endtask

    task automatic clear_q();
        q_addr.delete(); q_sat.delete(); q_wrap.delete(); q_cyc.delete();
        e_addr.delete(); e_sat.delete(); e_wrap.delete();
    endtask

    // Appends the expected writes of the job described by the current memories.
    task automatic build_model();
        int rr, kk, kw, nn;
        logic [95:0] s;
        rr = int'(in_mem[0][31:16]);
        kk = int'(in_mem[0][15:0]);
        kw = int'(wt_mem[0][31:16]);
        nn = int'(wt_mem[0][15:0]);
        exp_err = (rr == 0) || (kk == 0) || (nn == 0) || (kk != kw);
        exp_lat = exp_err ? 5 : NM * rr * nn * kk + 7;
        if (!exp_err) begin
            for (int m = 0; m < NM; m++)
                for (int r = 0; r < rr; r++)
                    for (int n = 0; n < nn; n++) begin
                        s = '0;
                        for (int k = 0; k < kk; k++)
                            s += 96'(in_mem[1 + r * kk + k]) * 96'(wt_mem[1 + m * kw * nn + n * kw + k]);
                        e_addr.push_back(16'(m * rr * nn + r * nn + n));
                        e_sat.push_back((s > 96'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0]);
                        e_wrap.push_back(s[31:0]);
                    end
        end
    endtask

    // Starts one job from a negedge; returns cycles from acceptance to dut_ready.
    task automatic run_job(output int lat);
        dut_valid = 1'b1;
        @(posedge clk); #1;
        dut_valid = 1'b0;
        lat = 1;
        while (s_ready !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", s_ready); else n_pass++;
        n_checks++; if (s_err !== 1'b0) $display("FAIL reset_err got %b want 0", s_err); else n_pass++;
        n_checks++; if (s_we !== 1'b0) $display("FAIL reset_we got %b want 0", s_we); else n_pass++;
        n_checks++; if (s_in_addr !== 16'd0) $display("FAIL reset_in_addr got %0d want 0", s_in_addr); else n_pass++;
        n_checks++; if (s_wt_addr !== 16'd0) $display("FAIL reset_wt_addr got %0d want 0", s_wt_addr); else n_pass++;
        n_checks++; if (s_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", s_wdata); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat;
        fill(2, 3, 3, 2, 0);
        clear_q();
        build_model();
        run_job(lat);
        n_checks++; if (lat !== 43) $display("FAIL directed_latency got %0d want 43", lat); else n_pass++;
        n_checks++; if (s_err !== 1'b0) $display("FAIL directed_err got %b want 0", s_err); else n_pass++;
        n_checks++; if (q_addr.size() != 12 || q_wrap.size() != 12)
            $display("FAIL directed_count got %0d/%0d want 12", q_addr.size(), q_wrap.size()); else n_pass++;
        for (int i = 0; i < q_addr.size() && i < q_wrap.size() && i < e_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 16'(i) || q_sat[i] !== e_sat[i] || q_wrap[i] !== e_wrap[i])
                $display("FAIL directed_write%0d got addr %0d data %h/%h want addr %0d data %h/%h",
                         i, q_addr[i], q_sat[i], q_wrap[i], i, e_sat[i], e_wrap[i]);
            else n_pass++;
        end
    endtask

    task automatic test_k1();
        int lat;
        in_mem[0] = {16'd1, 16'd1};
        wt_mem[0] = {16'd1, 16'd1};
        in_mem[1] = 32'd5;
        for (int i = 1; i <= NM; i++) wt_mem[i] = 32'd7;
        clear_q();
        run_job(lat);
        n_checks++; if (lat !== NM + 7) $display("FAIL k1_latency got %0d want %0d", lat, NM + 7); else n_pass++;
        n_checks++; if (q_addr.size() != NM || q_wrap.size() != NM)
            $display("FAIL k1_count got %0d/%0d want %0d", q_addr.size(), q_wrap.size(), NM); else n_pass++;
        for (int i = 0; i < q_addr.size() && i < q_wrap.size() && i < NM; i++) begin
            n_checks++;
            if (q_addr[i] !== 16'(i) || q_sat[i] !== 32'd35 || q_wrap[i] !== 32'd35 || q_cyc[i] !== q_cyc[0] + i)
                $display("FAIL k1_write%0d got addr %0d data %h/%h cycle_offset %0d want addr %0d data 35 cycle_offset %0d",
                         i, q_addr[i], q_sat[i], q_wrap[i], q_cyc[i] - q_cyc[0], i, i);
            else n_pass++;
        end
    endtask

    task automatic test_err();
        int lat;
        logic [31:0] hdr_in  [3] = '{{16'd2, 16'd3}, {16'd0, 16'd2}, {16'd2, 16'd2}};
        logic [31:0] hdr_wt  [3] = '{{16'd4, 16'd2}, {16'd2, 16'd2}, {16'd2, 16'd0}};
        for (int t = 0; t < 3; t++) begin
            in_mem[0] = hdr_in[t];
            wt_mem[0] = hdr_wt[t];
            clear_q();
            run_job(lat);
            n_checks++; if (s_err !== 1'b1 || w_err !== 1'b1)
                $display("FAIL err%0d_flag got %b/%b want 1", t, s_err, w_err); else n_pass++;
            n_checks++; if (q_addr.size() != 0) $display("FAIL err%0d_writes got %0d want 0", t, q_addr.size()); else n_pass++;
            n_checks++; if (lat !== 5) $display("FAIL err%0d_latency got %0d want 5", t, lat); else n_pass++;
        end
        fill(2, 2, 2, 2, 2);
        clear_q();
        build_model();
        run_job(lat);
        n_checks++; if (s_err !== 1'b0) $display("FAIL err_clear got %b want 0", s_err); else n_pass++;
        n_checks++; if (q_addr.size() != e_addr.size() || q_wrap.size() != e_addr.size())
            $display("FAIL err_clear_count got %0d/%0d want %0d", q_addr.size(), q_wrap.size(), e_addr.size()); else n_pass++;
    endtask

    task automatic test_sat();
        int lat;
        in_mem[0] = {16'd1, 16'd2};
        wt_mem[0] = {16'd2, 16'd1};
        for (int i = 1; i <= 2; i++) in_mem[i] = 32'hFFFF_FFFF;
        for (int i = 1; i <= 2 * NM; i++) wt_mem[i] = 32'hFFFF_FFFF;
        clear_q();
        run_job(lat);
        n_checks++; if (q_addr.size() != NM || q_wrap.size() != NM)
            $display("FAIL sat_count got %0d/%0d want %0d", q_addr.size(), q_wrap.size(), NM); else n_pass++;
        for (int i = 0; i < q_addr.size() && i < q_wrap.size(); i++) begin
            n_checks++;
            if (q_sat[i] !== 32'hFFFF_FFFF || q_wrap[i] !== 32'd2)
                $display("FAIL sat_write%0d got sat %h wrap %h want sat ffffffff wrap 00000002", i, q_sat[i], q_wrap[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, n;
        fill(2, 3, 3, 2, 2);
        clear_q();
        dut_valid = 1'b1;
        @(posedge clk); #1;
        dut_valid = 1'b0;
        n = 0;
        while (q_addr.size() < 5 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (s_ready !== 1'b1 || s_we !== 1'b0)
            $display("FAIL rstmid_state got ready %b we %b want ready 1 we 0", s_ready, s_we); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++; if (q_addr.size() != 5) $display("FAIL rstmid_writes got %0d want 5", q_addr.size()); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rstmid_idle got %b want 1", s_ready); else n_pass++;
        clear_q();
        build_model();
        run_job(lat);
        n_checks++; if (lat !== exp_lat) $display("FAIL rerun_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (q_addr.size() != e_addr.size() || q_wrap.size() != e_addr.size())
            $display("FAIL rerun_count got %0d/%0d want %0d", q_addr.size(), q_wrap.size(), e_addr.size()); else n_pass++;
        for (int i = 0; i < q_addr.size() && i < q_wrap.size() && i < e_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== e_addr[i] || q_sat[i] !== e_sat[i] || q_wrap[i] !== e_wrap[i])
                $display("FAIL rerun_write%0d got addr %0d data %h/%h want addr %0d data %h/%h",
                         i, q_addr[i], q_sat[i], q_wrap[i], e_addr[i], e_sat[i], e_wrap[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, want1;
        fill(1, 2, 2, 2, 2);
        clear_q();
        build_model();
        want1 = exp_lat;
        dut_valid = 1'b1;
        @(posedge clk); #1;
        lat1 = 1;
        while (s_ready !== 1'b1 && lat1 < 2000) begin
            @(posedge clk); #1;
            lat1++;
        end
        n_checks++; if (lat1 !== want1) $display("FAIL b2b_latency1 got %0d want %0d", lat1, want1); else n_pass++;
        // Second job's memories are swapped in while the engine sits in its single IDLE cycle.
        fill(2, 1, 1, 3, 2);
        build_model();
        @(posedge clk); #1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL b2b_restart got ready %b want 0", s_ready); else n_pass++;
        dut_valid = 1'b0;
        lat2 = 1;
        while (s_ready !== 1'b1 && lat2 < 2000) begin
            @(posedge clk); #1;
            lat2++;
        end
        @(negedge clk);
        n_checks++; if (lat2 !== exp_lat) $display("FAIL b2b_latency2 got %0d want %0d", lat2, exp_lat); else n_pass++;
        n_checks++; if (q_addr.size() != e_addr.size() || q_wrap.size() != e_addr.size())
            $display("FAIL b2b_count got %0d/%0d want %0d", q_addr.size(), q_wrap.size(), e_addr.size()); else n_pass++;
        for (int i = 0; i < q_addr.size() && i < q_wrap.size() && i < e_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== e_addr[i] || q_sat[i] !== e_sat[i] || q_wrap[i] !== e_wrap[i])
                $display("FAIL b2b_write%0d got addr %0d data %h/%h want addr %0d data %h/%h",
                         i, q_addr[i], q_sat[i], q_wrap[i], e_addr[i], e_sat[i], e_wrap[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, rr, kk, nn;
        for (int it = 0; it < 8; it++) begin
            rr = $urandom_range(1, 3);
            kk = $urandom_range(1, 3);
            nn = $urandom_range(1, 3);
            fill(rr, kk, kk, nn, 1 + (it % 2));
            clear_q();
            build_model();
            run_job(lat);
            n_checks++; if (lat !== exp_lat || s_err !== 1'b0)
                $display("FAIL rand%0d_latency got %0d err %b want %0d err 0", it, lat, s_err, exp_lat); else n_pass++;
            n_checks++; if (q_addr.size() != e_addr.size() || q_wrap.size() != e_addr.size())
                $display("FAIL rand%0d_count got %0d/%0d want %0d", it, q_addr.size(), q_wrap.size(), e_addr.size());
            else n_pass++;
            for (int i = 0; i < q_addr.size() && i < q_wrap.size() && i < e_addr.size(); i++) begin
                n_checks++;
                if (q_addr[i] !== e_addr[i] || q_sat[i] !== e_sat[i] || q_wrap[i] !== e_wrap[i])
                    $display("FAIL rand%0d_write%0d got addr %0d data %h/%h want addr %0d data %h/%h",
                             it, i, q_addr[i], q_sat[i], q_wrap[i], e_addr[i], e_sat[i], e_wrap[i]);
                else n_pass++;
            end
        end
        n_checks++; if (idle_bad !== 0) $display("FAIL idle_wdata got %0d nonzero cycles want 0", idle_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_k1();
        test_err();
        test_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning SRAM data width and element width (unsigned).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning SRAM address width.
REQ-003 SHALL have parameter NUM_MATS, default 3, range 1..4, meaning the number of weight matrices applied to one input matrix (for example Q/K/V).
REQ-004 SHALL have parameter SAT_EN, default 1, meaning 1 = saturate results to DATA_W and 0 = wrap modulo 2^DATA_W.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port dut_valid, input, 1 bit: job start request.
REQ-008 SHALL have port dut_ready, output, 1 bit: engine idle and results complete.
REQ-009 SHALL have port err, output, 1 bit: last job rejected for a header error; valid while dut_ready=1.
REQ-010 SHALL have ports in_rd_addr (output, ADDR_W) and in_rd_data (input, DATA_W): input SRAM read port.
REQ-011 SHALL have ports wt_rd_addr (output, ADDR_W) and wt_rd_data (input, DATA_W): weight SRAM read port.
REQ-012 SHALL have ports res_we (output, 1), res_wr_addr (output, ADDR_W) and res_wr_data (output, DATA_W): result SRAM write port.
REQ-013 SHALL NOT write the input or weight SRAMs.

Function
REQ-014 SHALL assume SRAM read latency of exactly 1 cycle: an address presented in cycle t returns data in cycle t+1.
REQ-015 SHALL read the input header at in_rd_addr 0 as R=[31:16] and K=[15:0]; A[r][k] is at 1+r*K+k.
REQ-016 SHALL read the weight header at wt_rd_addr 0 as Kw=[31:16] and N=[15:0]; matrix m element B_m[k][n] is at 1+m*Kw*N+n*Kw+k (column-major).
REQ-017 SHALL write C_m[r][n]=sum over k of A[r][k]*B_m[k][n] to res_wr_addr m*R*N+r*N+n, in order m, then r, then n.
REQ-018 SHALL implement states IDLE, HDR_REQ, HDR_WAIT, CHECK, RUN, DRAIN, DONE.
REQ-019 IDLE: dut_ready=1; when dut_valid=1 on a clock edge, SHALL go to HDR_REQ and deassert dut_ready in the next cycle.
REQ-020 HDR_REQ: SHALL drive address 0 on both read ports; HDR_WAIT SHALL capture both headers.
REQ-021 CHECK: if R=0, K=0, N=0 or K!=Kw, SHALL set err=1, perform no writes and go to DONE; otherwise SHALL clear err and go to RUN.
REQ-022 RUN: SHALL issue one (A,B) address pair per cycle with no bubbles, including between consecutive dot products, matrices and rows.
REQ-023 The MAC SHALL accumulate in a register at least 2*DATA_W+16 bits wide and reload with the product (not add) on k=0.
REQ-024 SHALL assert res_we for exactly one cycle, 2 cycles after the address of the final k of each dot product; res_wr_data SHALL be saturated (SAT_EN=1: min(sum, 2^DATA_W-1)) or truncated (SAT_EN=0).
REQ-025 After issuing the last address, SHALL go to DRAIN for 2 cycles, then DONE.
REQ-026 DONE: SHALL go to IDLE after 1 cycle; dut_ready SHALL rise in the cycle after DONE.
REQ-027 Total job latency (dut_valid accepted to dut_ready=1) SHALL be NUM_MATS*R*N*K+7 cycles for valid jobs and 5 cycles for rejected jobs.
REQ-028 SHALL ignore dut_valid outside IDLE; if dut_valid is held high, a new job SHALL start on the first IDLE cycle.
REQ-029 res_we SHALL be 0 in every state except RUN/DRAIN write cycles; res_wr_data SHALL be 0 when res_we=0.
REQ-030 Index counters (k, n, r, m) SHALL be sized from ADDR_W and wrap k->n->r->m with no off-by-one at K=1 or N=1.

Reset
REQ-031 While reset=1, SHALL enter IDLE and drive dut_ready=1, err=0, res_we=0, all addresses 0 and the accumulator to 0.
REQ-032 Reset asserted mid-job SHALL abort the job within one cycle with no further writes; the next job SHALL start cleanly.

Verification
REQ-033 Directed test: R=2, K=3, N=2, NUM_MATS=3, A and B=1..n -> 12 writes at addresses 0..11 matching the golden model, and dut_ready after 3*12+7=43 cycles.
REQ-034 Directed test: K=1, N=1, R=1, A=5, B=7 -> one write of 35 at address m per matrix, with no gaps between writes.
REQ-035 Directed test: Kw=4, K=3 -> err=1, no res_we, and dut_ready after 5 cycles; a following valid job clears err.
REQ-036 Directed test: SAT_EN=1, A=B=0xFFFFFFFF, K=2 -> write 0xFFFFFFFF; SAT_EN=0 -> the low 32 bits of the sum.
REQ-037 Directed test: reset pulsed in RUN after 5 writes -> no further res_we, IDLE with dut_ready=1, and a rerun producing correct results.
REQ-038 Directed test: dut_valid held high across two jobs -> second job starts on the first IDLE cycle, and results from both jobs are correct.
